// File: rtl/mismatch_pkg.sv
// mismatch_pkg
// Shared definitions for the mismatch_tracker scoreboard:
//   mt_state_e  - run-control FSM states
//   CNT_W_DEF   - default counter width
//   sat_inc     - saturating increment used by every counter
package mismatch_pkg;

   typedef enum logic [1:0] {
      MT_IDLE = 2'd0,
      MT_RUN  = 2'd1,
      MT_DONE = 2'd2
   } mt_state_e;

   localparam int CNT_W_DEF = 32;

   // Increment that sticks at max_v instead of wrapping. Operates on a wide
   // container so one function serves every counter width up to 63 bits.
   function automatic logic [63:0] sat_inc(input logic [63:0] v,
                                           input logic [63:0] max_v);
      return (v >= max_v) ? v : v + 64'd1;
   endfunction

endpackage

// File: rtl/mismatch_tracker_sat_counter.sv
// sat_counter
// CNT_W-bit saturating counter with synchronous clear and enable.
// Clear and enable in the same cycle yield 1: the clear is applied first,
// then the count, so a counter can be restarted on a cycle that also counts.
// Ports:
//   clk_i   - rising-edge clock
//   reset_i - synchronous active-high reset (counter -> 0)
//   clr_i   - synchronous clear
//   en_i    - count enable
//   cnt_o   - registered count value
module sat_counter
   import mismatch_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [63:0] MAX_V = (64'd1 << CNT_W) - 64'd1;

   logic [CNT_W-1:0] cnt_q, cnt_d, base;

   always_comb begin
      base  = clr_i ? '0 : cnt_q;
      cnt_d = base;
      if (en_i) cnt_d = CNT_W'(sat_inc(64'(base), MAX_V));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/mismatch_tracker.sv
// mismatch_tracker
// On-chip scoreboard: compares out_ref against out_dut under dc_mask on each
// valid sample in RUN, counts samples and mismatches, records the run cycle
// of the first mismatch and gives a pass/fail verdict on stop or timeout.
// Optional macro MISMATCH_CAPTURE_EN adds cap_ref/cap_dut/cap_bits, which
// latch the operands and failing bits of the first mismatch.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start, stop         - run control pulses
//   sample_valid        - compare inputs valid this cycle
//   out_ref, out_dut    - compared vectors
//   dc_mask             - 1 = don't-care bit
//   running, done, pass, timed_out - status / verdict
//   sample_cnt, error_cnt          - statistics
//   first_err_valid, first_err_cycle - first mismatch record
module mismatch_tracker
   import mismatch_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = 100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] out_ref,
   input  logic [WIDTH-1:0] out_dut,
   input  logic [WIDTH-1:0] dc_mask,
   output logic             running,
   output logic             done,
   output logic             pass,
   output logic             timed_out,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] error_cnt,
   output logic             first_err_valid,
`ifdef MISMATCH_CAPTURE_EN
   output logic [WIDTH-1:0] cap_ref,
   output logic [WIDTH-1:0] cap_dut,
   output logic [WIDTH-1:0] cap_bits,
`endif
   output logic [CNT_W-1:0] first_err_cycle
);

   // Last run cycle before a forced finish; unused when TIMEOUT == 0.
   localparam logic [63:0] TO_LAST = (TIMEOUT == 0) ? 64'd0 : 64'(TIMEOUT - 1);

   mt_state_e        state_q, state_d;
   logic             timed_out_q, timed_out_d;
   logic             fev_q, fev_d;
   logic [CNT_W-1:0] fec_q, fec_d;
   logic [CNT_W-1:0] cyc;

   logic             in_run, start_take, take, mism, first_hit, timeout_hit;
   logic [WIDTH-1:0] diff_bits;

   assign in_run      = (state_q == MT_RUN);
   // start is only honoured outside RUN; this also makes stop win over start.
   assign start_take  = start && !in_run;
   assign take        = in_run && sample_valid;
   assign diff_bits   = (out_ref ^ out_dut) & ~dc_mask;
   assign mism        = |diff_bits;
   assign first_hit   = take && mism && !fev_q;
   assign timeout_hit = (TIMEOUT != 0) && (64'(cyc) == TO_LAST);

   sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
      .clk_i(clk), .reset_i(reset), .clr_i(start_take), .en_i(take),
      .cnt_o(sample_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_error_cnt (
      .clk_i(clk), .reset_i(reset), .clr_i(start_take), .en_i(take && mism),
      .cnt_o(error_cnt)
   );

   // The start cycle itself is cycle 0, so clear-and-count on start leaves
   // the first RUN cycle at index 1.
   sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
      .clk_i(clk), .reset_i(reset), .clr_i(start_take),
      .en_i(in_run || start_take), .cnt_o(cyc)
   );

   always_comb begin
      state_d     = state_q;
      timed_out_d = timed_out_q;
      fev_d       = fev_q;
      fec_d       = fec_q;
      case (state_q)
         MT_IDLE, MT_DONE: begin
            if (start) begin
               state_d     = MT_RUN;
               timed_out_d = 1'b0;
               fev_d       = 1'b0;
               fec_d       = '0;
            end
         end
         MT_RUN: begin
            if (stop) begin
               state_d = MT_DONE;
            end else if (timeout_hit) begin
               state_d     = MT_DONE;
               timed_out_d = 1'b1;
            end
            if (first_hit) begin
               fev_d = 1'b1;
               fec_d = cyc;
            end
         end
         default: state_d = MT_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= MT_IDLE;
         timed_out_q <= 1'b0;
         fev_q       <= 1'b0;
         fec_q       <= '0;
      end else begin
         state_q     <= state_d;
         timed_out_q <= timed_out_d;
         fev_q       <= fev_d;
         fec_q       <= fec_d;
      end
   end

`ifdef MISMATCH_CAPTURE_EN
   logic [WIDTH-1:0] cap_ref_q, cap_ref_d;
   logic [WIDTH-1:0] cap_dut_q, cap_dut_d;
   logic [WIDTH-1:0] cap_bits_q, cap_bits_d;

   always_comb begin
      cap_ref_d  = cap_ref_q;
      cap_dut_d  = cap_dut_q;
      cap_bits_d = cap_bits_q;
      if (start_take) begin
         cap_ref_d  = '0;
         cap_dut_d  = '0;
         cap_bits_d = '0;
      end else if (first_hit) begin
         cap_ref_d  = out_ref;
         cap_dut_d  = out_dut;
         cap_bits_d = diff_bits;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cap_ref_q  <= '0;
         cap_dut_q  <= '0;
         cap_bits_q <= '0;
      end else begin
         cap_ref_q  <= cap_ref_d;
         cap_dut_q  <= cap_dut_d;
         cap_bits_q <= cap_bits_d;
      end
   end

   assign cap_ref  = cap_ref_q;
   assign cap_dut  = cap_dut_q;
   assign cap_bits = cap_bits_q;
`endif

   assign running         = in_run;
   assign done            = (state_q == MT_DONE);
   assign timed_out       = timed_out_q;
   assign first_err_valid = fev_q;
   assign first_err_cycle = fec_q;
   assign pass            = done && (error_cnt == '0) && !timed_out_q;

endmodule

// File: tb/tb_mismatch_tracker.sv
module tb_mismatch_tracker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       sv = 1'b0;
   logic [3:0] r = 4'h0;
   logic [3:0] d = 4'h0;
   logic [3:0] m = 4'h0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // u_main: WIDTH 4, no timeout
   logic        a_run, a_done, a_pass, a_to, a_fev;
   logic [31:0] a_sc, a_ec, a_fec;
   // u_one: WIDTH 1, TIMEOUT 16
   logic        b_run, b_done, b_pass, b_to, b_fev;
   logic [31:0] b_sc, b_ec, b_fec;
   // u_sat: CNT_W 4
   logic        c_run, c_done, c_pass, c_to, c_fev;
   logic [3:0]  c_sc, c_ec, c_fec;
`ifdef MISMATCH_CAPTURE_EN
   logic [3:0] a_cr, a_cd, a_cb, c_cr, c_cd, c_cb;
   logic [0:0] b_cr, b_cd, b_cb;
`endif

   mismatch_tracker #(.WIDTH(4), .CNT_W(32), .TIMEOUT(0)) u_main (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .sample_valid(sv),
      .out_ref(r), .out_dut(d), .dc_mask(m),
      .running(a_run), .done(a_done), .pass(a_pass), .timed_out(a_to),
      .sample_cnt(a_sc), .error_cnt(a_ec), .first_err_valid(a_fev),
`ifdef MISMATCH_CAPTURE_EN
      .cap_ref(a_cr), .cap_dut(a_cd), .cap_bits(a_cb),
`endif
      .first_err_cycle(a_fec)
   );

   mismatch_tracker #(.WIDTH(1), .CNT_W(32), .TIMEOUT(16)) u_one (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .sample_valid(sv),
      .out_ref(r[0]), .out_dut(d[0]), .dc_mask(m[0]),
      .running(b_run), .done(b_done), .pass(b_pass), .timed_out(b_to),
      .sample_cnt(b_sc), .error_cnt(b_ec), .first_err_valid(b_fev),
`ifdef MISMATCH_CAPTURE_EN
      .cap_ref(b_cr), .cap_dut(b_cd), .cap_bits(b_cb),
`endif
      .first_err_cycle(b_fec)
   );

   mismatch_tracker #(.WIDTH(4), .CNT_W(4), .TIMEOUT(0)) u_sat (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .sample_valid(sv),
      .out_ref(r), .out_dut(d), .dc_mask(m),
      .running(c_run), .done(c_done), .pass(c_pass), .timed_out(c_to),
      .sample_cnt(c_sc), .error_cnt(c_ec), .first_err_valid(c_fev),
`ifdef MISMATCH_CAPTURE_EN
      .cap_ref(c_cr), .cap_dut(c_cd), .cap_bits(c_cb),
`endif
      .first_err_cycle(c_fec)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      sv = 1'b0;
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      n_cmp++; if (a_run !== 1'b0) begin n_err++; $display("FAIL reset_running got %b want 0", a_run); end
      n_cmp++; if (a_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", a_done); end
      n_cmp++; if (a_pass !== 1'b0) begin n_err++; $display("FAIL reset_pass got %b want 0", a_pass); end
      n_cmp++; if (a_sc !== 32'd0) begin n_err++; $display("FAIL reset_sample_cnt got %0d want 0", a_sc); end
      n_cmp++; if (a_ec !== 32'd0) begin n_err++; $display("FAIL reset_error_cnt got %0d want 0", a_ec); end
      n_cmp++; if (a_fev !== 1'b0) begin n_err++; $display("FAIL reset_fev got %b want 0", a_fev); end
   endtask

   task automatic test_all_match();
      m = 4'h0;
      pulse_start();
      n_cmp++; if (a_run !== 1'b1) begin n_err++; $display("FAIL allm_running got %b want 1", a_run); end
      for (int i = 0; i < 20; i++) begin
         sv = 1'b1; r = 4'(i); d = 4'(i);
         step();
      end
      pulse_stop();
      n_cmp++; if (a_done !== 1'b1) begin n_err++; $display("FAIL allm_done got %b want 1", a_done); end
      n_cmp++; if (a_sc !== 32'd20) begin n_err++; $display("FAIL allm_sample_cnt got %0d want 20", a_sc); end
      n_cmp++; if (a_ec !== 32'd0) begin n_err++; $display("FAIL allm_error_cnt got %0d want 0", a_ec); end
      n_cmp++; if (a_pass !== 1'b1) begin n_err++; $display("FAIL allm_pass got %b want 1", a_pass); end
      n_cmp++; if (a_fev !== 1'b0) begin n_err++; $display("FAIL allm_fev got %b want 0", a_fev); end
   endtask

   task automatic test_single_mismatch();
      m = 4'h0;
      pulse_start();
      for (int k = 1; k <= 10; k++) begin
         sv = 1'b1;
         r = {3'b000, 1'(k)};
         d = (k == 7) ? {3'b000, ~1'(k)} : {3'b000, 1'(k)};
         stop = (k == 10);
         step();
         if (k == 6) begin
            n_cmp++; if (b_ec !== 32'd0) begin n_err++; $display("FAIL single_pre_err got %0d want 0", b_ec); end
         end
         if (k == 7) begin
            n_cmp++; if (b_ec !== 32'd1) begin n_err++; $display("FAIL single_latency got %0d want 1", b_ec); end
         end
      end
      stop = 1'b0; sv = 1'b0;
      n_cmp++; if (b_done !== 1'b1) begin n_err++; $display("FAIL single_done got %b want 1", b_done); end
      n_cmp++; if (b_sc !== 32'd10) begin n_err++; $display("FAIL single_sample_cnt got %0d want 10", b_sc); end
      n_cmp++; if (b_ec !== 32'd1) begin n_err++; $display("FAIL single_error_cnt got %0d want 1", b_ec); end
      n_cmp++; if (b_fec !== 32'd7) begin n_err++; $display("FAIL single_first_cycle got %0d want 7", b_fec); end
      n_cmp++; if (b_pass !== 1'b0) begin n_err++; $display("FAIL single_pass got %b want 0", b_pass); end
   endtask

   task automatic test_mask();
      pulse_start();
      sv = 1'b1; r = 4'b1010; d = 4'b1011; m = 4'b0001;
      step();
      n_cmp++; if (a_ec !== 32'd0) begin n_err++; $display("FAIL mask_dc_err got %0d want 0", a_ec); end
      n_cmp++; if (a_sc !== 32'd1) begin n_err++; $display("FAIL mask_dc_samples got %0d want 1", a_sc); end
      m = 4'b0000;
      step();
      n_cmp++; if (a_ec !== 32'd1) begin n_err++; $display("FAIL mask_nodc_err got %0d want 1", a_ec); end
      n_cmp++; if (a_fec !== 32'd2) begin n_err++; $display("FAIL mask_first_cycle got %0d want 2", a_fec); end
      pulse_stop();
      n_cmp++; if (a_pass !== 1'b0) begin n_err++; $display("FAIL mask_pass got %b want 0", a_pass); end
   endtask

   task automatic test_timeout();
      int n;
      sv = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      n = 1;
      while (b_done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      n_cmp++; if (n !== 16) begin n_err++; $display("FAIL timeout_latency got %0d want 16", n); end
      n_cmp++; if (b_to !== 1'b1) begin n_err++; $display("FAIL timeout_flag got %b want 1", b_to); end
      n_cmp++; if (b_pass !== 1'b0) begin n_err++; $display("FAIL timeout_pass got %b want 0", b_pass); end
      n_cmp++; if (b_ec !== 32'd0) begin n_err++; $display("FAIL timeout_err got %0d want 0", b_ec); end
      n_cmp++; if (a_run !== 1'b1) begin n_err++; $display("FAIL timeout_disabled got %b want 1", a_run); end
      step(); step();
      n_cmp++; if (b_done !== 1'b1) begin n_err++; $display("FAIL timeout_hold got %b want 1", b_done); end
      pulse_stop();
   endtask

   task automatic test_stop_with_mismatch();
      m = 4'h0;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         sv = 1'b1; r = 4'h3; d = 4'h3;
         step();
      end
      r = 4'h5; d = 4'h6; stop = 1'b1;
      step();
      stop = 1'b0; sv = 1'b0;
      n_cmp++; if (a_done !== 1'b1) begin n_err++; $display("FAIL stopmis_done got %b want 1", a_done); end
      n_cmp++; if (a_sc !== 32'd4) begin n_err++; $display("FAIL stopmis_samples got %0d want 4", a_sc); end
      n_cmp++; if (a_ec !== 32'd1) begin n_err++; $display("FAIL stopmis_err got %0d want 1", a_ec); end
      n_cmp++; if (a_fec !== 32'd4) begin n_err++; $display("FAIL stopmis_first_cycle got %0d want 4", a_fec); end
      n_cmp++; if (a_pass !== 1'b0) begin n_err++; $display("FAIL stopmis_pass got %b want 0", a_pass); end
`ifdef MISMATCH_CAPTURE_EN
      n_cmp++; if (a_cr !== 4'h5) begin n_err++; $display("FAIL cap_ref got %h want 5", a_cr); end
      n_cmp++; if (a_cd !== 4'h6) begin n_err++; $display("FAIL cap_dut got %h want 6", a_cd); end
      n_cmp++; if (a_cb !== 4'h3) begin n_err++; $display("FAIL cap_bits got %h want 3", a_cb); end
`endif
   endtask

   task automatic test_start_in_run();
      m = 4'h0;
      pulse_start();
      sv = 1'b1; r = 4'h1; d = 4'h2;
      step(); step();
      r = 4'h2; start = 1'b1;
      step();
      start = 1'b0; sv = 1'b0;
      n_cmp++; if (a_run !== 1'b1) begin n_err++; $display("FAIL startrun_running got %b want 1", a_run); end
      n_cmp++; if (a_sc !== 32'd3) begin n_err++; $display("FAIL startrun_samples got %0d want 3", a_sc); end
      n_cmp++; if (a_ec !== 32'd2) begin n_err++; $display("FAIL startrun_err got %0d want 2", a_ec); end
      n_cmp++; if (a_fec !== 32'd1) begin n_err++; $display("FAIL startrun_first_cycle got %0d want 1", a_fec); end
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      n_cmp++; if (a_done !== 1'b1) begin n_err++; $display("FAIL startstop_done got %b want 1", a_done); end
      n_cmp++; if (a_sc !== 32'd3) begin n_err++; $display("FAIL startstop_samples got %0d want 3", a_sc); end
   endtask

   task automatic test_start_in_done();
      start = 1'b1; sv = 1'b1; r = 4'h1; d = 4'h8; m = 4'h0;
      step();
      start = 1'b0; sv = 1'b0;
      n_cmp++; if (a_run !== 1'b1) begin n_err++; $display("FAIL startdone_running got %b want 1", a_run); end
      n_cmp++; if (a_sc !== 32'd0) begin n_err++; $display("FAIL startdone_samples got %0d want 0", a_sc); end
      n_cmp++; if (a_ec !== 32'd0) begin n_err++; $display("FAIL startdone_err got %0d want 0", a_ec); end
      n_cmp++; if (a_fev !== 1'b0) begin n_err++; $display("FAIL startdone_fev got %b want 0", a_fev); end
   endtask

   task automatic test_reset_mid_run();
      sv = 1'b1; r = 4'h0; d = 4'hF; m = 4'h0;
      step(); step();
      n_cmp++; if (a_ec !== 32'd2) begin n_err++; $display("FAIL rstmid_pre_err got %0d want 2", a_ec); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++; if (a_run !== 1'b0) begin n_err++; $display("FAIL rstmid_running got %b want 0", a_run); end
      n_cmp++; if (a_done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b want 0", a_done); end
      n_cmp++; if (a_sc !== 32'd0) begin n_err++; $display("FAIL rstmid_samples got %0d want 0", a_sc); end
      n_cmp++; if (a_ec !== 32'd0) begin n_err++; $display("FAIL rstmid_err got %0d want 0", a_ec); end
      n_cmp++; if (a_fev !== 1'b0) begin n_err++; $display("FAIL rstmid_fev got %b want 0", a_fev); end
      n_cmp++; if (a_fec !== 32'd0) begin n_err++; $display("FAIL rstmid_fec got %0d want 0", a_fec); end
      // still asserting a mismatching sample: IDLE must ignore it
      step();
      sv = 1'b0;
      n_cmp++; if (a_sc !== 32'd0) begin n_err++; $display("FAIL idle_ignore got %0d want 0", a_sc); end
      n_cmp++; if (a_run !== 1'b0) begin n_err++; $display("FAIL idle_stays got %b want 0", a_run); end
   endtask

   task automatic test_saturation();
      m = 4'h0;
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         sv = 1'b1; r = 4'hA; d = 4'h5;
         step();
      end
      n_cmp++; if (c_ec !== 4'd15) begin n_err++; $display("FAIL sat_err got %0d want 15", c_ec); end
      n_cmp++; if (c_sc !== 4'd15) begin n_err++; $display("FAIL sat_samples got %0d want 15", c_sc); end
      n_cmp++; if (c_fec !== 4'd1) begin n_err++; $display("FAIL sat_first_cycle got %0d want 1", c_fec); end
      step(); step();
      sv = 1'b0;
      n_cmp++; if (c_ec !== 4'd15) begin n_err++; $display("FAIL sat_err_hold got %0d want 15", c_ec); end
      n_cmp++; if (c_sc !== 4'd15) begin n_err++; $display("FAIL sat_samples_hold got %0d want 15", c_sc); end
      pulse_stop();
      n_cmp++; if (c_pass !== 1'b0) begin n_err++; $display("FAIL sat_pass got %b want 0", c_pass); end
   endtask

   initial begin
      test_reset();
      test_all_match();
      test_single_mismatch();
      test_mask();
      test_timeout();
      test_stop_with_mismatch();
      test_start_in_run();
      test_start_in_done();
      test_reset_mid_run();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
